fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
Time-multiplexed MAC sequencer sitting directly downstream of the filter timing generator and upstream of a single DSP58 slice. Accepts one input sample per frame into a circular delay line, then issues FILTER_LENGTH (sample, coefficient-address) operand pairs to the DSP58 in consecutive cycles. It waits out the DSP pipeline latency, captures the accumulated P result and presents it as one filter output with a valid pulse.

Parameters:
FILTER_LENGTH, 16, number of taps; any value 2..64, not restricted to powers of two
DSP_DELAY, 4, DSP58 pipeline latency in cycles from operand issue to P valid; range 1..15
DATA_W, 16, sample width (signed)
P_W, 58, DSP58 P output width (signed)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sample_in  in  DATA_W  signed input sample
sample_valid  in  1  sample_in is valid this cycle
sample_ready  out  1  sequencer can accept a sample this cycle
dsp_a  out  DATA_W  sample operand to DSP58 A port
coef_addr  out  clog2(FILTER_LENGTH)  coefficient ROM address (tap index)
dsp_ce  out  1  DSP operand clock-enable; high only on issue cycles
dsp_load  out  1  high on first tap: DSP computes P=A*B, otherwise P=P+A*B
dsp_p  in  P_W  DSP58 P result
y_out  out  P_W  captured filter output, held until next capture
y_valid  out  1  one-cycle pulse when y_out updates
overrun  out  1  sticky: sample_valid seen while sample_ready low
overrun_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst_n=0): state IDLE, wr_ptr=0, delay line all zero, tap=0, drain counter=0, sample_ready=1, dsp_ce=0, dsp_load=0, dsp_a=0, coef_addr=0, y_out=0, y_valid=0, overrun=0. Reset mid-frame aborts the frame; no y_valid is produced for it.
- States: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE: sample_ready=1. On sample_valid: write sample_in to line[wr_ptr], set newest=wr_ptr, advance wr_ptr (FILTER_LENGTH-1 wraps to 0), tap=0, go to RUN.
- RUN, one tap per cycle for k=0..FILTER_LENGTH-1: dsp_ce=1, coef_addr=k, dsp_a=line[(newest-k) mod FILTER_LENGTH], dsp_load=(k==0). Index wrap uses explicit compare/add, not bit masking. After k=FILTER_LENGTH-1, load drain=DSP_DELAY and go to DRAIN.
- DRAIN: dsp_ce=0, dsp_a/coef_addr hold the last value. Drain decrements each cycle. On the cycle it reaches 1, next edge: y_out<=dsp_p, y_valid=1 for exactly one cycle, go to IDLE.
- Latency: sample accepted at edge 0. Taps issue in cycles 1..FILTER_LENGTH. y_valid is high in cycle FILTER_LENGTH+DSP_DELAY+1. Max throughput is one sample per FILTER_LENGTH+DSP_DELAY+1 cycles (21 at defaults).
- sample_ready=0 in RUN and DRAIN. In these states sample_valid=1 drops the sample: overrun<=1, line unchanged.
- overrun_clr has priority over setting overrun in the same cycle.
- Back-to-back: a sample may be accepted in the same cycle y_valid is high, since the state is already IDLE.
- Arithmetic is performed in the DSP; the sequencer carries P_W bits unmodified, with no rounding or saturation.

Decomposition:
- Shared package fir_pkg: FILTER_LENGTH/DSP_DELAY/DATA_W/P_W defaults, state enum (IDLE, RUN, DRAIN), tap index width function clog2.
- One sub-module: fir_delay_line. Circular sample RAM with write port and one combinational read port, read address computed mod FILTER_LENGTH. Registers only, reset to zero.

Test Plan:
- Bench DSP model: DSP_DELAY-stage pipeline with coefficient ROM c[k]=k+1. Impulse test: after reset send 1, then 15 zeros (each when ready) -> y_out sequence 1,2,3,...,16; the 17th sample yields 0.
- Latency: sample_valid at cycle 0 with defaults -> dsp_ce high cycles 1..16, dsp_load high only cycle 1, y_valid high only cycle 21, sample_ready low cycles 1..20.
- Overrun: pulse sample_valid with value 7 in cycle 5 of RUN -> overrun=1, next y_out unaffected. Assert overrun_clr and sample_valid-while-busy in the same cycle -> overrun=0.
- Wrap with FILTER_LENGTH=12: feed 13 samples of 1 -> 13th output equals sum c[0..11]=78; dsp_a read addresses wrap 0->11 correctly.
- Reset mid-RUN at tap 6 -> all outputs are their reset values next cycle, no y_valid. The next sample after release behaves as a first sample from an all-zero delay line.
- Constant input 2 at full throughput -> from the 16th output on, y_out=2*136=272 each frame.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, FSM state type and tap-index width helper for the FIR MAC sequencer
package fir_pkg;
   localparam int DEF_FILTER_LENGTH = 16;
   localparam int DEF_DSP_DELAY     = 4;
   localparam int DEF_DATA_W        = 16;
   localparam int DEF_P_W           = 58;
   localparam int DRAIN_W           = 4;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: circular sample store with one write port and a combinational newest-minus-offset read port
module fir_delay_line import fir_pkg::*; #(
   parameter int DEPTH = DEF_FILTER_LENGTH,
   parameter int W     = DEF_DATA_W,
   localparam int AW   = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic [AW-1:0] base_i,
   input  logic [AW-1:0] off_i,
   output logic [W-1:0]  rd_data_o
);
   logic [W-1:0]  line_q [DEPTH];
   logic [AW-1:0] rd_addr;

   // read index wraps by compare/add so non-power-of-two depths stay inside 0..DEPTH-1
   always_comb
      rd_addr = (base_i >= off_i) ? base_i - off_i
                                  : AW'({1'b0, base_i} + (AW+1)'(DEPTH) - {1'b0, off_i});

   // sample storage, cleared to zero on reset so a fresh filter sees silence
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      else if (we_i)
         line_q[wr_addr_i] <= wr_data_i;

   assign rd_data_o = line_q[rd_addr];
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: accepts one sample per frame and walks all taps through a single DSP, then captures P
module fir_mac_sequencer import fir_pkg::*; #(
   parameter int FILTER_LENGTH = DEF_FILTER_LENGTH,
   parameter int DSP_DELAY     = DEF_DSP_DELAY,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int P_W           = DEF_P_W,
   localparam int TW           = clog2(FILTER_LENGTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic [DATA_W-1:0] dsp_a,
   output logic [TW-1:0]     coef_addr,
   output logic              dsp_ce,
   output logic              dsp_load,
   input  logic [P_W-1:0]    dsp_p,
   output logic [P_W-1:0]    y_out,
   output logic              y_valid,
   output logic              overrun,
   input  logic              overrun_clr
);
   localparam logic [TW-1:0] LAST = TW'(FILTER_LENGTH - 1);

   state_t              state_q, state_d;
   logic [TW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [TW-1:0]       newest_q, newest_d;
   logic [TW-1:0]       tap_q, tap_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;
   logic [P_W-1:0]      y_out_q, y_out_d;
   logic                y_valid_q, y_valid_d;
   logic                overrun_q, overrun_d;
   logic                we;

   // state register and all datapath registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         newest_q  <= '0;
         tap_q     <= '0;
         drain_q   <= '0;
         y_out_q   <= '0;
         y_valid_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         newest_q  <= newest_d;
         tap_q     <= tap_d;
         drain_q   <= drain_d;
         y_out_q   <= y_out_d;
         y_valid_q <= y_valid_d;
         overrun_q <= overrun_d;
      end

   // next state: accept in IDLE, one tap per cycle in RUN, wait out the DSP pipe in DRAIN
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      newest_d  = newest_q;
      tap_d     = tap_q;
      drain_d   = drain_q;
      y_out_d   = y_out_q;
      y_valid_d = 1'b0;
      we        = 1'b0;
      overrun_d = overrun_clr ? 1'b0 : (sample_valid && state_q != IDLE) ? 1'b1 : overrun_q;
      case (state_q)
         IDLE:
            if (sample_valid) begin
               we       = 1'b1;
               newest_d = wr_ptr_q;
               wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + TW'(1);
               tap_d    = '0;
               state_d  = RUN;
            end
         RUN:
            if (tap_q == LAST) begin
               drain_d = DRAIN_W'(DSP_DELAY);
               state_d = DRAIN;
            end else
               tap_d = tap_q + TW'(1);
         DRAIN: begin
            drain_d = drain_q - DRAIN_W'(1);
            if (drain_q == DRAIN_W'(1)) begin
               y_out_d   = dsp_p;
               y_valid_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   fir_delay_line #(.DEPTH(FILTER_LENGTH), .W(DATA_W)) u_line (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (we),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (sample_in),
      .base_i    (newest_q),
      .off_i     (tap_q),
      .rd_data_o (dsp_a)
   );

   assign sample_ready = state_q == IDLE;
   assign dsp_ce       = state_q == RUN;
   assign dsp_load     = dsp_ce && tap_q == '0;
   assign coef_addr    = tap_q;
   assign y_out        = y_out_q;
   assign y_valid      = y_valid_q;
   assign overrun      = overrun_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: frame-level reference model plus DSP model, checked every cycle, with directed vectors
module tb_fir_mac_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        sv [2];
   logic [15:0] din [2];
   logic        rdy [2], ce [2], ld [2], yv [2], ovf [2];
   logic [15:0] da [2];
   logic [3:0]  ca [2];
   logic [57:0] yo [2], dp [2];

   int     n_run = 0, n_fail = 0, cyc = 0;
   bit     act [2], ovr [2];
   int     e_m [2];
   longint ey [2], yq [2];
   int     h [2][16];
   longint acc [2];
   longint pipe [2][16];
   logic [57:0] ylog0 [$], ylog1 [$];
   int     ycyc0 [$];

   function automatic int len(input int g); return g == 0 ? 16 : 12; endfunction
   function automatic int dly(input int g); return g == 0 ? 4 : 2; endfunction

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      fir_mac_sequencer #(.FILTER_LENGTH(g == 0 ? 16 : 12), .DSP_DELAY(g == 0 ? 4 : 2)) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .sample_in    (din[g]),
         .sample_valid (sv[g]),
         .sample_ready (rdy[g]),
         .dsp_a        (da[g]),
         .coef_addr    (ca[g]),
         .dsp_ce       (ce[g]),
         .dsp_load     (ld[g]),
         .dsp_p        (dp[g]),
         .y_out        (yo[g]),
         .y_valid      (yv[g]),
         .overrun      (ovf[g]),
         .overrun_clr  (clr)
      );
      assign dp[g] = pipe[g][g == 0 ? 3 : 1][57:0];
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_run++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   // DSP58 model: coefficient c[k]=k+1, accumulate on ce, fixed-depth output pipe
   always @(posedge clk) begin
      longint na;
      for (int g = 0; g < 2; g++) begin
         na = !rst_n ? 0 : !ce[g] ? acc[g]
            : (ld[g] ? 0 : acc[g]) + longint'($signed(da[g])) * (longint'(ca[g]) + 1);
         acc[g]     <= na;
         pipe[g][0] <= na;
         for (int i = 1; i < 16; i++) pipe[g][i] <= !rst_n ? 0 : pipe[g][i-1];
      end
   end

   // frame-level model: sample history, expected result and busy window per accepted sample
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         int l, d;
         bit r;
         l = len(g);
         d = dly(g);
         if (!rst_n) begin
            act[g] = 0;
            ovr[g] = 0;
            yq[g]  = 0;
            for (int k = 0; k < 16; k++) h[g][k] = 0;
         end else begin
            r = !act[g] || (cyc - e_m[g] >= l + d);
            ovr[g] = clr ? 1'b0 : (sv[g] && !r) ? 1'b1 : ovr[g];
            if (act[g] && cyc - e_m[g] == l + d - 1) yq[g] = ey[g];
            if (sv[g] && r) begin
               for (int k = 15; k > 0; k--) h[g][k] = h[g][k-1];
               h[g][0] = int'($signed(din[g]));
               ey[g] = 0;
               for (int k = 0; k < l; k++) ey[g] += longint'(k + 1) * h[g][k];
               e_m[g] = cyc + 1;
               act[g] = 1;
            end
         end
      end
      cyc++;
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk)
      if (rst_n)
         for (int g = 0; g < 2; g++) begin
            int l, d, rel;
            bit busy, issue;
            l = len(g);
            d = dly(g);
            rel = cyc - e_m[g];
            busy = act[g] && rel <= l + d - 1;
            issue = act[g] && rel < l;
            chk($sformatf("ready%0d", g), 64'(rdy[g]), 64'(!busy));
            chk($sformatf("ce%0d", g), 64'(ce[g]), 64'(issue));
            chk($sformatf("load%0d", g), 64'(ld[g]), 64'(act[g] && rel == 0));
            if (issue) begin
               chk($sformatf("coef%0d", g), 64'(ca[g]), 64'(rel));
               chk($sformatf("dsp_a%0d", g), 64'(da[g]), 64'(16'(h[g][rel])));
            end
            chk($sformatf("y_valid%0d", g), 64'(yv[g]), 64'(act[g] && rel == l + d));
            chk($sformatf("y_out%0d", g), 64'(yo[g]), 64'(58'(yq[g])));
            chk($sformatf("overrun%0d", g), 64'(ovf[g]), 64'(ovr[g]));
            if (yv[g] && g == 0) begin ylog0.push_back(yo[g]); ycyc0.push_back(cyc); end
            if (yv[g] && g == 1) ylog1.push_back(yo[g]);
         end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wait_ready(input int g);
      int n;
      n = 0;
      while (!rdy[g] && n < 100) begin @(posedge clk); #2; n++; end
      if (!rdy[g]) begin
         n_run++;
         n_fail++;
         $display("FAIL timeout%0d: sample_ready got 0 want 1", g);
      end
   endtask

   task automatic send(input int g, input int v);
      wait_ready(g);
      sv[g] = 1'b1;
      din[g] = 16'(v);
      @(posedge clk); #2;
      sv[g] = 1'b0;
   endtask

   task automatic finish_frame(input int g);
      wait_ready(g);
      @(negedge clk); #1;
   endtask

   initial begin
      int c0, n0;
      #1000000;
      $display("FAIL watchdog: sim time exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, n0;
      sv[0] = 1'b0; sv[1] = 1'b0; din[0] = '0; din[1] = '0;
      idle(3);
      chk("rst_ready", 64'(rdy[0]), 64'd1);
      chk("rst_ce", 64'(ce[0]), 64'd0);
      chk("rst_load", 64'(ld[0]), 64'd0);
      chk("rst_dsp_a", 64'(da[0]), 64'd0);
      chk("rst_coef", 64'(ca[0]), 64'd0);
      chk("rst_y_out", 64'(yo[0]), 64'd0);
      chk("rst_y_valid", 64'(yv[0]), 64'd0);
      chk("rst_overrun", 64'(ovf[0]), 64'd0);
      rst_n = 1'b1;
      idle(2);
      c0 = cyc;
      for (int i = 0; i < 17; i++) send(0, i == 0 ? 1 : 0);
      finish_frame(0);
      chk("imp_count", 64'(ylog0.size()), 64'd17);
      chk("latency", 64'(ycyc0[0] - c0), 64'd21);
      chk("throughput", 64'(ycyc0[1] - ycyc0[0]), 64'd21);
      for (int i = 0; i < 16; i++) chk($sformatf("imp_y%0d", i), 64'(ylog0[i]), 64'(i + 1));
      chk("imp_y16", 64'(ylog0[16]), 64'd0);
      send(0, 3);
      idle(4);
      sv[0] = 1'b1; din[0] = 16'd7;
      idle(1);
      sv[0] = 1'b0;
      chk("ovr_set", 64'(ovf[0]), 64'd1);
      finish_frame(0);
      chk("ovr_y", 64'(ylog0[$]), 64'd3);
      send(0, 0);
      idle(3);
      clr = 1'b1; sv[0] = 1'b1; din[0] = 16'd7;
      idle(1);
      clr = 1'b0; sv[0] = 1'b0;
      chk("ovr_clr_prio", 64'(ovf[0]), 64'd0);
      finish_frame(0);
      chk("ovr_y2", 64'(ylog0[$]), 64'd6);
      for (int i = 0; i < 16; i++) send(0, 2);
      finish_frame(0);
      chk("const_y", 64'(ylog0[$]), 64'd272);
      send(0, 5);
      idle(6);
      rst_n = 1'b0;
      #1;
      chk("midrst_ce", 64'(ce[0]), 64'd0);
      chk("midrst_y_valid", 64'(yv[0]), 64'd0);
      chk("midrst_dsp_a", 64'(da[0]), 64'd0);
      chk("midrst_coef", 64'(ca[0]), 64'd0);
      chk("midrst_ready", 64'(rdy[0]), 64'd1);
      chk("midrst_y_out", 64'(yo[0]), 64'd0);
      n0 = ylog0.size();
      idle(3);
      rst_n = 1'b1;
      idle(25);
      chk("midrst_no_y", 64'(ylog0.size()), 64'(n0));
      send(0, 1);
      finish_frame(0);
      chk("midrst_first", 64'(ylog0[$]), 64'd1);
      for (int i = 0; i < 13; i++) send(1, 1);
      finish_frame(1);
      chk("wrap_count", 64'(ylog1.size()), 64'd13);
      chk("wrap_y0", 64'(ylog1[0]), 64'd1);
      chk("wrap_y11", 64'(ylog1[11]), 64'd78);
      chk("wrap_y12", 64'(ylog1[12]), 64'd78);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
